ledstrip_frame: RTL

- Parametrised successor to the single-LED sender: transmits a complete APA102-style strip frame (start frame, NUM_LEDS LED frames, end frame) from one `frame_start` pulse.
- Fetches pixel colours from upstream frame storage over a request/valid handshake.
- Applies a per-frame 5-bit global brightness and a selectable colour byte order.
- Contains its own clock-divided SPI shifter; sits between the pattern generator/frame buffer and the strip pins.

---
 rtl/ledstrip_pkg.sv | 48 ++++
 rtl/ledstrip_if.sv | 16 +
 rtl/ledstrip_frame_spi_shift.sv | 66 ++++++
 rtl/ledstrip_frame.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ledstrip_pkg.sv
// Shared definitions for the APA102-style strip frame sender: FSM encoding,
// colour order codes, frame framing constants and small helper functions.
package ledstrip_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_FRAME,
        ST_FETCH,
        ST_LED_HDR,
        ST_LED_C0,
        ST_LED_C1,
        ST_LED_C2,
        ST_END_FRAME,
        ST_DONE
    } state_t;

    localparam int ORDER_BGR = 0;
    localparam int ORDER_RGB = 1;
    localparam int ORDER_GRB = 2;

    localparam int         START_BYTES = 4;
    localparam logic [2:0] HDR_PREFIX  = 3'b111;
    localparam logic [7:0] END_BYTE    = 8'hFF;

    // The strip needs at least half a clock per LED on the trailing frame.
    function automatic int end_bytes(input int num_leds);
        int bytes;
        bytes = (num_leds + 15) / 16;
        return (bytes < 4) ? 4 : bytes;
    endfunction

    function automatic logic [7:0] color_byte(input int order, input logic [1:0] slot,
                                              input logic [7:0] blue, input logic [7:0] green,
                                              input logic [7:0] red);
        logic [7:0] first, second, third;
        case (order)
            ORDER_RGB: begin first = red;   second = green; third = blue; end
            ORDER_GRB: begin first = green; second = red;   third = blue; end
            default:   begin first = blue;  second = green; third = red;  end
        endcase
        case (slot)
            2'd0:    return first;
            2'd1:    return second;
            default: return third;
        endcase
    endfunction

endpackage

// File: rtl/ledstrip_if.sv
// Pixel fetch handshake between the strip sender (master) and the upstream
// frame storage (slave).
interface ledstrip_if #(parameter int IDX_W = 1);
    logic             pix_req;
    logic [IDX_W-1:0] pix_index;
    logic             pix_valid;
    logic [7:0]       pix_blue;
    logic [7:0]       pix_green;
    logic [7:0]       pix_red;

    modport master (output pix_req, pix_index,
                    input  pix_valid, pix_blue, pix_green, pix_red);

    modport slave  (input  pix_req, pix_index,
                    output pix_valid, pix_blue, pix_green, pix_red);
endinterface

// File: rtl/ledstrip_frame_spi_shift.sv
// Clock-divided SPI byte shifter, MSB first, sck idling low; ready is also
// high on the final clock of a byte so the next byte follows without a gap.
module spi_shift #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       mosi,
    output logic       sck
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             phase_end;
    logic             byte_end;

    assign phase_end = (div_cnt == DIV_LAST);
    assign byte_end  = busy && sck && phase_end && (bit_cnt == 3'd7);
    assign ready     = !busy || byte_end;

    // Each bit: CLK_DIV clocks low (mosi already set), then CLK_DIV clocks high.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            mosi    <= 1'b0;
            sck     <= 1'b0;
        end else if (load && ready) begin
            busy    <= 1'b1;
            shreg   <= data;
            bit_cnt <= '0;
            div_cnt <= '0;
            mosi    <= data[7];
            sck     <= 1'b0;
        end else if (busy) begin
            if (!phase_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        busy <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                        mosi    <= shreg[6];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ledstrip_frame.sv
// Sends one full APA102-style strip frame per frame_start, fetching each
// pixel from upstream storage and prefetching the next while the current shifts.
module ledstrip_frame
    import ledstrip_pkg::*;
#(
    parameter int NUM_LEDS    = 60,
    parameter int CLK_DIV     = 4,
    parameter int COLOR_ORDER = 0
) (
    input  logic       ledstrip_clk,
    input  logic       ledstrip_reset,
    input  logic       frame_start,
    input  logic [4:0] brightness,
    ledstrip_if.master pix,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       mosi,
    output logic       sck
);

    localparam int               IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int               END_BYTES = end_bytes(NUM_LEDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LEDS - 1);

    state_t           state, state_next;
    logic [4:0]       bright_q;
    logic [IDX_W-1:0] led_idx;
    logic [IDX_W-1:0] fetch_idx;
    logic [6:0]       byte_cnt;
    logic             fetch_on;
    logic             pix_full;
    logic [7:0]       buf_b, buf_g, buf_r;
    logic [7:0]       cur_b, cur_g, cur_r;
    logic             sh_load;
    logic             sh_ready;
    logic [7:0]       sh_data;

    assign pix.pix_req   = fetch_on;
    assign pix.pix_index = fetch_idx;
    assign frame_busy    = (state != ST_IDLE) && (state != ST_DONE);
    assign frame_done    = (state == ST_DONE);

    spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk   (ledstrip_clk),
        .reset (ledstrip_reset),
        .load  (sh_load),
        .data  (sh_data),
        .ready (sh_ready),
        .mosi  (mosi),
        .sck   (sck)
    );

    // Each byte state loads its byte as soon as the shifter can take it.
    always_comb begin
        state_next = state;
        sh_load    = 1'b0;
        sh_data    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (frame_start) state_next = ST_START_FRAME;
            end
            ST_START_FRAME: begin
                sh_load = sh_ready;
                if (sh_ready && byte_cnt == 7'(START_BYTES - 1)) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (pix_full) state_next = ST_LED_HDR;
            end
            ST_LED_HDR: begin
                sh_data = {HDR_PREFIX, bright_q};
                sh_load = sh_ready;
                if (sh_ready) state_next = ST_LED_C0;
            end
            ST_LED_C0: begin
                sh_data = color_byte(COLOR_ORDER, 2'd0, cur_b, cur_g, cur_r);
                sh_load = sh_ready;
                if (sh_ready) state_next = ST_LED_C1;
            end
            ST_LED_C1: begin
                sh_data = color_byte(COLOR_ORDER, 2'd1, cur_b, cur_g, cur_r);
                sh_load = sh_ready;
                if (sh_ready) state_next = ST_LED_C2;
            end
            ST_LED_C2: begin
                sh_data = color_byte(COLOR_ORDER, 2'd2, cur_b, cur_g, cur_r);
                sh_load = sh_ready;
                if (sh_ready) state_next = (led_idx == LAST_IDX) ? ST_END_FRAME : ST_FETCH;
            end
            ST_END_FRAME: begin
                sh_data = END_BYTE;
                if (byte_cnt < 7'(END_BYTES)) sh_load = sh_ready;
                else if (sh_ready)            state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Pixel buffer is copied to cur_* on leaving FETCH, freeing it for the prefetch.
    always_ff @(posedge ledstrip_clk) begin
        if (ledstrip_reset) begin
            state     <= ST_IDLE;
            bright_q  <= '0;
            led_idx   <= '0;
            fetch_idx <= '0;
            byte_cnt  <= '0;
            fetch_on  <= 1'b0;
            pix_full  <= 1'b0;
            buf_b     <= '0;
            buf_g     <= '0;
            buf_r     <= '0;
            cur_b     <= '0;
            cur_g     <= '0;
            cur_r     <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && frame_start) begin
                bright_q <= brightness;
                led_idx  <= '0;
                byte_cnt <= '0;
                pix_full <= 1'b0;
            end
            if (sh_load && (state == ST_START_FRAME || state == ST_END_FRAME))
                byte_cnt <= (state_next == ST_FETCH) ? 7'd0 : byte_cnt + 7'd1;
            if (state == ST_START_FRAME && state_next == ST_FETCH) begin
                fetch_on  <= 1'b1;
                fetch_idx <= '0;
            end
            if (state == ST_LED_C0 && sh_load && led_idx != LAST_IDX) begin
                fetch_on  <= 1'b1;
                fetch_idx <= led_idx + 1'b1;
            end
            if (fetch_on && pix.pix_valid) begin
                fetch_on <= 1'b0;
                pix_full <= 1'b1;
                buf_b    <= pix.pix_blue;
                buf_g    <= pix.pix_green;
                buf_r    <= pix.pix_red;
            end
            if (state == ST_FETCH && pix_full) begin
                pix_full <= 1'b0;
                cur_b    <= buf_b;
                cur_g    <= buf_g;
                cur_r    <= buf_r;
            end
            if (state == ST_LED_C2 && state_next == ST_FETCH)
                led_idx <= led_idx + 1'b1;
        end
    end

endmodule
